// File: rtl/iobus_pkg.sv
// Shared op-codes, FSM states and the OTTER I/O address map used by the
// bus initiator, its comparator and anything that drives or checks them.
package iobus_pkg;

   typedef enum logic [1:0] {
      OP_WR   = 2'b00,
      OP_RD   = 2'b01,
      OP_POLL = 2'b10
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RWAIT,
      ST_SAMPLE,
      ST_RESP
   } state_t;

   // Memory-mapped peripheral registers on the I/O bus
   localparam logic [31:0] ADDR_SWITCHES = 32'h1100_0000;
   localparam logic [31:0] ADDR_BUTTONS  = 32'h1100_4000;
   localparam logic [31:0] ADDR_TC_CSR   = 32'h1100_8000;
   localparam logic [31:0] ADDR_TC_CNT   = 32'h1100_8004;
   localparam logic [31:0] ADDR_LEDS     = 32'h1100_C000;
   localparam logic [31:0] ADDR_SEGS     = 32'h1101_0000;
   localparam logic [31:0] ADDR_ANODES   = 32'h1101_4000;

endpackage

// File: rtl/iobus_poll_cmp.sv
// Masked compare of a bus sample against the poll match value, plus the
// poll attempt counter and its terminal-count flag.
module iobus_poll_cmp #(
   parameter int TMO_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [31:0]      sample_i,
   input  logic [31:0]      match_i,
   input  logic [31:0]      mask_i,
   input  logic [TMO_W-1:0] tmo_i,
   output logic             hit_o,
   output logic             term_o
);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Only bits selected by the mask take part in the match
   assign hit_o  = (((sample_i ^ match_i) & mask_i) == 32'h0);
   assign term_o = (cnt_q == tmo_i);

endmodule

// File: rtl/iobus_initiator.sv
// OTTER I/O bus initiator: executes one write, read or masked poll per
// command and returns a single response; state is exported on DBG_STATE.
module iobus_initiator
   import iobus_pkg::*;
#(
   parameter int RD_LAT = 0,
   parameter int TMO_W  = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [1:0]       CMD_OP,
   input  logic [31:0]      CMD_ADDR,
   input  logic [31:0]      CMD_WDATA,
   input  logic [31:0]      CMD_MASK,
   input  logic [TMO_W-1:0] CMD_TMO,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [31:0]      RSP_RDATA,
   output logic             RSP_ERR,
   output logic [31:0]      IOBUS_ADDR,
   output logic [31:0]      IOBUS_OUT,
   output logic             IOBUS_WR,
   input  logic [31:0]      IOBUS_IN,
   output state_t           DBG_STATE
);

   localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
   localparam logic [LAT_W-1:0] LAT_GAP  = LAT_W'(RD_LAT);

   state_t           state_q, state_d;
   logic [31:0]      addr_q, out_q, match_q, mask_q, rdata_q;
   logic [TMO_W-1:0] tmo_q;
   logic [LAT_W-1:0] lat_q, lat_d, lat_last;
   logic             poll_q, gap_q, err_q;
   logic             cmd_ready, rsp_valid, wr_strobe, cmd_fire, cnt_inc;
   logic             hit, term;

   // Handshakes: a transfer happens on a rising edge where VALID and READY are
   // both high; VALID never waits on READY and the response is held until taken.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      wr_strobe = 1'b0;
      cnt_inc   = 1'b0;
      lat_d     = '0;
      lat_last  = gap_q ? LAT_GAP : LAT_LAST;
      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (CMD_VALID) begin
               if (CMD_OP == OP_WR) begin
                  state_d = ST_WRITE;
               end else if (RD_LAT > 0) begin
                  state_d = ST_RWAIT;
               end else begin
                  state_d = ST_SAMPLE;
               end
            end
         end
         ST_WRITE: begin
            wr_strobe = 1'b1;
            state_d   = ST_RESP;
         end
         ST_RWAIT: begin
            // Retries wait one extra cycle: that is the idle gap between attempts
            if (lat_q == lat_last) begin
               state_d = ST_SAMPLE;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (!poll_q || hit || term) begin
               state_d = ST_RESP;
            end else begin
               cnt_inc = 1'b1;
               state_d = ST_RWAIT;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (RSP_READY) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_fire = cmd_ready & CMD_VALID;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         addr_q  <= '0;
         out_q   <= '0;
         match_q <= '0;
         mask_q  <= '0;
         tmo_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         poll_q  <= 1'b0;
         gap_q   <= 1'b0;
         lat_q   <= '0;
      end else begin
         lat_q <= lat_d;
         if (cmd_fire) begin
            addr_q  <= CMD_ADDR;
            match_q <= CMD_WDATA;
            mask_q  <= CMD_MASK;
            tmo_q   <= CMD_TMO;
            poll_q  <= (CMD_OP == OP_POLL);
            gap_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (CMD_OP == OP_WR) begin
               out_q <= CMD_WDATA;
            end
         end
         if (state_q == ST_SAMPLE) begin
            rdata_q <= IOBUS_IN;
            err_q   <= poll_q & ~hit & term;
         end
         if (cnt_inc) begin
            gap_q <= 1'b1;
         end
      end
   end

   iobus_poll_cmp #(
      .TMO_W (TMO_W)
   ) u_cmp (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .clr_i    (cmd_fire),
      .inc_i    (cnt_inc),
      .sample_i (IOBUS_IN),
      .match_i  (match_q),
      .mask_i   (mask_q),
      .tmo_i    (tmo_q),
      .hit_o    (hit),
      .term_o   (term)
   );

   // Strobes are masked by RESET so an aborted operation emits nothing
   assign CMD_READY  = cmd_ready & ~RESET;
   assign RSP_VALID  = rsp_valid & ~RESET;
   assign IOBUS_WR   = wr_strobe & ~RESET;
   assign RSP_RDATA  = rdata_q;
   assign RSP_ERR    = err_q;
   assign IOBUS_ADDR = addr_q;
   assign IOBUS_OUT  = out_q;
   assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_iobus_initiator.sv
// Directed bench for iobus_initiator: one instance with RD_LAT=0, one with
// RD_LAT=2, each attached to a small bus model of the timer and switches.
module tb_iobus_initiator;
   import iobus_pkg::*;

   localparam int TMO_W = 16;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   logic             cmd_valid [2];
   logic             cmd_ready [2];
   logic [1:0]       cmd_op    [2];
   logic [31:0]      cmd_addr  [2];
   logic [31:0]      cmd_wdata [2];
   logic [31:0]      cmd_mask  [2];
   logic [TMO_W-1:0] cmd_tmo   [2];
   logic             rsp_valid [2];
   logic             rsp_ready [2];
   logic [31:0]      rsp_rdata [2];
   logic             rsp_err   [2];
   logic [31:0]      io_addr   [2];
   logic [31:0]      io_out    [2];
   logic [31:0]      io_in     [2];
   logic             io_wr     [2];
   state_t           dbg       [2];

   int          sample_cnt [2] = '{0, 0};
   int          wr_cnt     [2] = '{0, 0};
   int          base       [2] = '{0, 0};
   logic [31:0] wr_addr    [2];
   logic [31:0] wr_data    [2];

   int n_cmp  = 0;
   int n_fail = 0;

   iobus_initiator #(.RD_LAT(0), .TMO_W(TMO_W)) dut0 (
      .CLK(clk), .RESET(rst),
      .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]), .CMD_OP(cmd_op[0]),
      .CMD_ADDR(cmd_addr[0]), .CMD_WDATA(cmd_wdata[0]), .CMD_MASK(cmd_mask[0]),
      .CMD_TMO(cmd_tmo[0]), .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]),
      .RSP_RDATA(rsp_rdata[0]), .RSP_ERR(rsp_err[0]), .IOBUS_ADDR(io_addr[0]),
      .IOBUS_OUT(io_out[0]), .IOBUS_WR(io_wr[0]), .IOBUS_IN(io_in[0]),
      .DBG_STATE(dbg[0])
   );

   iobus_initiator #(.RD_LAT(2), .TMO_W(TMO_W)) dut1 (
      .CLK(clk), .RESET(rst),
      .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]), .CMD_OP(cmd_op[1]),
      .CMD_ADDR(cmd_addr[1]), .CMD_WDATA(cmd_wdata[1]), .CMD_MASK(cmd_mask[1]),
      .CMD_TMO(cmd_tmo[1]), .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]),
      .RSP_RDATA(rsp_rdata[1]), .RSP_ERR(rsp_err[1]), .IOBUS_ADDR(io_addr[1]),
      .IOBUS_OUT(io_out[1]), .IOBUS_WR(io_wr[1]), .IOBUS_IN(io_in[1]),
      .DBG_STATE(dbg[1])
   );

   // Bus model: the timer count gains bit 4 from the third sample of a command on
   function automatic logic [31:0] bus_model(input logic [31:0] a, input int n);
      case (a)
         ADDR_TC_CSR:   return 32'h0000_1234;
         ADDR_TC_CNT:   return (n >= 2) ? 32'h0000_0013 : 32'h0000_0003;
         ADDR_SWITCHES: return 32'h0000_00F0;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   always_comb begin
      for (int g = 0; g < 2; g++) begin
         io_in[g] = bus_model(io_addr[g], sample_cnt[g] - base[g]);
      end
   end

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (dbg[g] == ST_SAMPLE) sample_cnt[g] <= sample_cnt[g] + 1;
         if (io_wr[g]) begin
            wr_cnt[g]  <= wr_cnt[g] + 1;
            wr_addr[g] <= io_addr[g];
            wr_data[g] <= io_out[g];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   typedef struct {
      int          dut;
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mask;
      logic [15:0] tmo;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      int          exp_samples;
   } vec_t;

   vec_t vecs [12];

   task automatic run_vec(input vec_t v, input int idx);
      int d;
      int lat;
      int wr0;
      d = v.dut;
      @(negedge clk);
      wr0     = wr_cnt[d];
      base[d] = sample_cnt[d];
      cmd_op[d]    = v.op;
      cmd_addr[d]  = v.addr;
      cmd_wdata[d] = v.wdata;
      cmd_mask[d]  = v.mask;
      cmd_tmo[d]   = v.tmo;
      cmd_valid[d] = 1'b1;
      chk1($sformatf("v%0d cmd_ready", idx), cmd_ready[d], 1'b1);
      @(posedge clk);
      #1 cmd_valid[d] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid[d] && lat < 100);
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d rdata", idx), rsp_rdata[d], v.exp_rdata);
      chk1($sformatf("v%0d err", idx), rsp_err[d], v.exp_err);
      chk($sformatf("v%0d samples", idx), sample_cnt[d] - base[d], v.exp_samples);
      for (int i = 0; i < v.hold; i++) begin
         cmd_op[d]    = OP_WR;
         cmd_valid[d] = 1'b1;
         @(negedge clk);
         chk1($sformatf("v%0d hold%0d rsp_valid", idx, i), rsp_valid[d], 1'b1);
         chk($sformatf("v%0d hold%0d rdata", idx, i), rsp_rdata[d], v.exp_rdata);
         chk1($sformatf("v%0d hold%0d cmd_ready", idx, i), cmd_ready[d], 1'b0);
      end
      cmd_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      chk1($sformatf("v%0d rsp_valid drop", idx), rsp_valid[d], 1'b0);
      chk1($sformatf("v%0d back to idle", idx), cmd_ready[d], 1'b1);
      chk($sformatf("v%0d write strobes", idx), wr_cnt[d] - wr0, v.exp_wr);
      if (v.exp_wr != 0) begin
         chk($sformatf("v%0d wr addr", idx), wr_addr[d], v.addr);
         chk($sformatf("v%0d wr data", idx), wr_data[d], v.wdata);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int wr0;
      int seen;
      vecs[0]  = '{0, OP_WR,   ADDR_LEDS,     32'h0000_A5A5, 32'h0,      16'd0,  0,  32'h0,      1'b0, 2,  1, 0};
      vecs[1]  = '{0, OP_RD,   ADDR_TC_CSR,   32'h0,         32'h0,      16'd0,  10, 32'h1234,   1'b0, 2,  0, 1};
      vecs[2]  = '{1, OP_RD,   ADDR_TC_CSR,   32'h0,         32'h0,      16'd0,  0,  32'h1234,   1'b0, 4,  0, 1};
      vecs[3]  = '{0, OP_POLL, ADDR_TC_CNT,   32'h10,        32'h10,     16'd10, 0,  32'h13,     1'b0, 6,  0, 3};
      vecs[4]  = '{0, OP_POLL, ADDR_SWITCHES, 32'h100,       32'h100,    16'd4,  0,  32'hF0,     1'b1, 10, 0, 5};
      vecs[5]  = '{0, OP_POLL, ADDR_SWITCHES, 32'h100,       32'h100,    16'd0,  0,  32'hF0,     1'b1, 2,  0, 1};
      vecs[6]  = '{0, 2'b11,   ADDR_TC_CSR,   32'h0,         32'h0,      16'd0,  0,  32'h1234,   1'b0, 2,  0, 1};
      vecs[7]  = '{0, OP_POLL, ADDR_TC_CSR,   32'h1000,      32'hF000,   16'd3,  0,  32'h1234,   1'b0, 2,  0, 1};
      vecs[8]  = '{1, OP_POLL, ADDR_TC_CNT,   32'h10,        32'h10,     16'd10, 0,  32'h13,     1'b0, 12, 0, 3};
      vecs[9]  = '{1, OP_POLL, ADDR_SWITCHES, 32'h100,       32'h100,    16'd2,  0,  32'hF0,     1'b1, 12, 0, 3};
      vecs[10] = '{0, OP_WR,   ADDR_SEGS,     32'hDEAD_BEEF, 32'h0,      16'd0,  0,  32'h0,      1'b0, 2,  1, 0};
      vecs[11] = '{0, OP_RD,   ADDR_TC_CSR,   32'h0,         32'h0,      16'd0,  0,  32'h1234,   1'b0, 2,  0, 1};

      // Clock/reset
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         cmd_valid[g] = 1'b0; cmd_op[g] = 2'b00; cmd_addr[g] = '0;
         cmd_wdata[g] = '0;   cmd_mask[g] = '0; cmd_tmo[g] = '0;
         rsp_ready[g] = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk1("reset cmd_ready", cmd_ready[0], 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk1("post-reset cmd_ready", cmd_ready[0], 1'b1);
      chk1("post-reset rsp_valid", rsp_valid[0], 1'b0);
      chk("post-reset rdata", rsp_rdata[0], 32'h0);
      chk1("post-reset err", rsp_err[0], 1'b0);
      chk("post-reset addr", io_addr[0], 32'h0);
      chk("post-reset out", io_out[0], 32'h0);
      chk1("post-reset wr", io_wr[0], 1'b0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Bus registers keep their last values while idle
      chk("idle addr held", io_addr[0], ADDR_TC_CSR);
      chk("idle out held", io_out[0], 32'hDEAD_BEEF);

      // Reset right after a write handshake: no strobe may escape
      @(negedge clk);
      wr0 = wr_cnt[0];
      cmd_op[0] = OP_WR; cmd_addr[0] = ADDR_LEDS; cmd_wdata[0] = 32'h5555_5555;
      cmd_valid[0] = 1'b1;
      @(posedge clk);
      #1 cmd_valid[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk1("abort write no strobe", io_wr[0], 1'b0);
      @(negedge clk);
      chk("abort write addr", io_addr[0], 32'h0);
      chk("abort write out", io_out[0], 32'h0);
      chk("abort write strobe count", wr_cnt[0] - wr0, 0);
      rst = 1'b0;

      // Reset during a poll's read-wait on the RD_LAT=2 instance
      @(negedge clk);
      cmd_op[1] = OP_POLL; cmd_addr[1] = ADDR_SWITCHES; cmd_wdata[1] = 32'h100;
      cmd_mask[1] = 32'h100; cmd_tmo[1] = 16'd10; cmd_valid[1] = 1'b1;
      @(posedge clk);
      #1 cmd_valid[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk1("abort poll rsp_valid", rsp_valid[1], 1'b0);
      chk("abort poll addr", io_addr[1], 32'h0);
      chk("abort poll rdata", rsp_rdata[1], 32'h0);
      chk1("abort poll err", rsp_err[1], 1'b0);
      chk1("abort poll cmd_ready in reset", cmd_ready[1], 1'b0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) seen++;
      end
      chk("abort poll no response", seen, 0);
      run_vec(vecs[2], 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
